rtc_alarm_core: RTL and testbench



---
 rtl/rtc_pkg.sv | 78 +++++++
 rtl/rtc_alarm_slot.sv | 57 +++++
 rtl/rtc_alarm_core.sv | 135 +++++++++++++
 tb/tb_rtc_alarm_core.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC alarm core.
// Packed 20-bit BCD time layout, digit limits, and helper functions for
// validating and converting hours between 12 h and 24 h form.
package rtc_pkg;

  localparam int TIME_W = 20;

  localparam int H1_LSB = 18;
  localparam int H1_W   = 2;
  localparam int H0_LSB = 14;
  localparam int H0_W   = 4;
  localparam int M1_LSB = 11;
  localparam int M1_W   = 3;
  localparam int M0_LSB = 7;
  localparam int M0_W   = 4;
  localparam int S1_LSB = 4;
  localparam int S1_W   = 3;
  localparam int S0_LSB = 0;
  localparam int S0_W   = 4;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX  = 3'd5;
  localparam logic [1:0] H1_MAX    = 2'd2;
  localparam logic [5:0] HOUR_MAX  = 6'd23;

  typedef struct packed {
    logic [H1_W-1:0] h1;
    logic [H0_W-1:0] h0;
    logic [M1_W-1:0] m1;
    logic [M0_W-1:0] m0;
    logic [S1_W-1:0] s1;
    logic [S0_W-1:0] s0;
  } time_t;

  // Binary hour; 6 bits so that out-of-range digits cannot wrap into range.
  function automatic logic [5:0] hour_of(time_t t);
    return 6'(t.h1) * 6'd10 + 6'(t.h0);
  endfunction

  function automatic time_t with_hour(time_t t, logic [5:0] h);
    time_t r;
    r    = t;
    r.h1 = 2'(h / 6'd10);
    r.h0 = 4'(h % 6'd10);
    return r;
  endfunction

  function automatic logic digits_valid(time_t t);
    return (t.h1 <= H1_MAX) && (t.h0 <= UNITS_MAX) &&
           (t.m1 <= TENS_MAX) && (t.m0 <= UNITS_MAX) &&
           (t.s1 <= TENS_MAX) && (t.s0 <= UNITS_MAX);
  endfunction

  function automatic logic bcd_valid_24h(time_t t);
    return digits_valid(t) && (hour_of(t) <= HOUR_MAX);
  endfunction

  function automatic logic bcd_valid_12h(time_t t);
    return digits_valid(t) && (hour_of(t) >= 6'd1) && (hour_of(t) <= 6'd12);
  endfunction

  function automatic time_t to_24h(time_t t, logic pm);
    logic [5:0] h;
    h = hour_of(t);
    if (h == 6'd12) h = pm ? 6'd12 : 6'd0;
    else if (pm)    h = h + 6'd12;
    return with_hour(t, h);
  endfunction

  function automatic time_t to_12h(time_t t);
    logic [5:0] h;
    h = hour_of(t);
    if (h == 6'd0)       h = 6'd12;
    else if (h > 6'd12)  h = h - 6'd12;
    return with_hour(t, h);
  endfunction

endpackage

// File: rtl/rtc_alarm_slot.sv
// rtc_alarm_slot: one alarm slot - stored 24 h time, enable and sticky ring.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   wr_i          validated write to this slot (stores value/enable, clears ring)
//   en_i          enable bit written with the slot
//   value_i       alarm time to store
//   inc_i         time register increments on this edge
//   time_i        time value after that increment
//   ack_i         ring clear request
//   ring_o        sticky ring flag
module rtc_alarm_slot
  import rtc_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_i,
  input  logic  en_i,
  input  time_t value_i,
  input  logic  inc_i,
  input  time_t time_i,
  input  logic  ack_i,
  output logic  ring_o
);

  time_t value_q;
  logic  en_q;
  logic  ring_q;
  logic  ring_d;
  logic  match;

  assign match = inc_i && en_q && (time_i == value_q);

  // A rewrite beats a coincident match; a match beats a coincident ack.
  always_comb begin
    ring_d = ring_q;
    if (wr_i)        ring_d = 1'b0;
    else if (match)  ring_d = 1'b1;
    else if (ack_i)  ring_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      en_q    <= 1'b0;
      ring_q  <= 1'b0;
    end else begin
      if (wr_i) begin
        value_q <= value_i;
        en_q    <= en_i;
      end
      ring_q <= ring_d;
    end
  end

  assign ring_o = ring_q;

endmodule

// File: rtl/rtc_alarm_core.sv
// rtc_alarm_core: synchronous BCD real-time clock with prescaler, 12/24 h
// display and NUM_ALARMS alarm slots.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   mode_12h      12 h display and set interpretation
//   set_time      load set_value (with set_pm in 12 h mode)
//   alarm_wr      write alarm slot alarm_id with alarm_value / alarm_en_in
//   alarm_ack     per-slot ring clear
//   hh_mm_ss      registered, mode-converted display time
//   am_pm         internal hour >= 12
//   sec_tick      pulse on each one-second increment
//   set_err       pulse on a rejected set or alarm write
//   alarm_ring    sticky per-slot match flags
module rtc_alarm_core
  import rtc_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int NUM_ALARMS = 4,
  parameter int AID_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_12h,
  input  logic                  set_time,
  input  logic [TIME_W-1:0]     set_value,
  input  logic                  set_pm,
  input  logic                  alarm_wr,
  input  logic [AID_W-1:0]      alarm_id,
  input  logic [TIME_W-1:0]     alarm_value,
  input  logic                  alarm_en_in,
  input  logic [NUM_ALARMS-1:0] alarm_ack,
  output logic [TIME_W-1:0]     hh_mm_ss,
  output logic                  am_pm,
  output logic                  sec_tick,
  output logic                  set_err,
  output logic [NUM_ALARMS-1:0] alarm_ring
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  time_t         time_q, time_d, time_inc;
  time_t         disp_q, disp_d;
  logic          am_pm_q, sec_tick_q, set_err_q;

  time_t set_t, alarm_t;
  logic  set_ok, set_load, wrap, inc, alarm_ok, alarm_wr_ok;

  assign set_t   = set_value;
  assign alarm_t = alarm_value;

  assign set_ok      = mode_12h ? bcd_valid_12h(set_t) : bcd_valid_24h(set_t);
  assign set_load    = set_time && set_ok;
  assign wrap        = (presc_q == PRE_LAST);
  assign inc         = wrap && !set_load;
  assign alarm_ok    = bcd_valid_24h(alarm_t);
  assign alarm_wr_ok = alarm_wr && alarm_ok;

  // Full carry cascade resolved combinationally in one cycle.
  always_comb begin
    time_inc = time_q;
    if (time_q.s0 != UNITS_MAX) time_inc.s0 = time_q.s0 + 4'd1;
    else begin
      time_inc.s0 = '0;
      if (time_q.s1 != TENS_MAX) time_inc.s1 = time_q.s1 + 3'd1;
      else begin
        time_inc.s1 = '0;
        if (time_q.m0 != UNITS_MAX) time_inc.m0 = time_q.m0 + 4'd1;
        else begin
          time_inc.m0 = '0;
          if (time_q.m1 != TENS_MAX) time_inc.m1 = time_q.m1 + 3'd1;
          else begin
            time_inc.m1 = '0;
            time_inc = with_hour(time_inc, (hour_of(time_q) == HOUR_MAX) ?
                                           6'd0 : hour_of(time_q) + 6'd1);
          end
        end
      end
    end
  end

  // An accepted set restarts the second; a rejected one leaves counting alone.
  always_comb begin
    presc_d = presc_q + PW'(1);
    time_d  = time_q;
    if (set_load) begin
      presc_d = '0;
      time_d  = mode_12h ? to_24h(set_t, set_pm) : set_t;
    end else if (wrap) begin
      presc_d = '0;
      time_d  = time_inc;
    end
    disp_d = mode_12h ? to_12h(time_d) : time_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      time_q     <= '0;
      disp_q     <= '0;
      am_pm_q    <= 1'b0;
      sec_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      time_q     <= time_d;
      disp_q     <= disp_d;
      am_pm_q    <= (hour_of(time_d) >= 6'd12);
      sec_tick_q <= inc;
      set_err_q  <= (set_time && !set_ok) || (alarm_wr && !alarm_ok);
    end
  end

  // Out-of-range alarm_id matches no slot, so the write simply falls away.
  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
    rtc_alarm_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (alarm_wr_ok && (32'(alarm_id) == g)),
      .en_i    (alarm_en_in),
      .value_i (alarm_t),
      .inc_i   (inc),
      .time_i  (time_inc),
      .ack_i   (alarm_ack[g]),
      .ring_o  (alarm_ring[g])
    );
  end

  assign hh_mm_ss = disp_q;
  assign am_pm    = am_pm_q;
  assign sec_tick = sec_tick_q;
  assign set_err  = set_err_q;

endmodule

// File: tb/tb_rtc_alarm_core.sv
module tb_rtc_alarm_core;
  import rtc_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int NA      = 4;
  localparam int AW      = 3;
  localparam int DAY     = 86400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode_12h = 1'b0;
  logic          set_time = 1'b0;
  logic [19:0]   set_value = '0;
  logic          set_pm = 1'b0;
  logic          alarm_wr = 1'b0;
  logic [AW-1:0] alarm_id = '0;
  logic [19:0]   alarm_value = '0;
  logic          alarm_en_in = 1'b0;
  logic [NA-1:0] alarm_ack = '0;
  logic [19:0]   hh_mm_ss;
  logic          am_pm, sec_tick, set_err;
  logic [NA-1:0] alarm_ring;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rtc_alarm_core #(.CLK_DIV(CLK_DIV), .NUM_ALARMS(NA), .AID_W(AW)) dut (
    .clk(clk), .rst(rst), .mode_12h(mode_12h), .set_time(set_time),
    .set_value(set_value), .set_pm(set_pm), .alarm_wr(alarm_wr),
    .alarm_id(alarm_id), .alarm_value(alarm_value), .alarm_en_in(alarm_en_in),
    .alarm_ack(alarm_ack), .hh_mm_ss(hh_mm_ss), .am_pm(am_pm),
    .sec_tick(sec_tick), .set_err(set_err), .alarm_ring(alarm_ring)
  );

  // ---------------- helpers: packed BCD <-> plain integers ----------------
  function automatic int dg(logic [19:0] v, int lsb, int w);
    return int'(v >> lsb) & ((1 << w) - 1);
  endfunction

  function automatic logic [19:0] pk_d(int h1, int h0, int m1, int m0, int s1, int s0);
    logic [19:0] r;
    r = (20'(h1) << H1_LSB) | (20'(h0) << H0_LSB) | (20'(m1) << M1_LSB) |
        (20'(m0) << M0_LSB) | (20'(s1) << S1_LSB) | (20'(s0) << S0_LSB);
    return r;
  endfunction

  function automatic logic [19:0] pk(int h, int m, int s);
    return pk_d(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
  endfunction

  function automatic logic [19:0] pk_secs(int t);
    return pk(t / 3600, (t / 60) % 60, t % 60);
  endfunction

  function automatic bit time_ok(logic [19:0] v, bit m12);
    int h;
    if (dg(v, H1_LSB, 2) > 2 || dg(v, H0_LSB, 4) > 9 || dg(v, M1_LSB, 3) > 5 ||
        dg(v, M0_LSB, 4) > 9 || dg(v, S1_LSB, 3) > 5 || dg(v, S0_LSB, 4) > 9)
      return 1'b0;
    h = dg(v, H1_LSB, 2) * 10 + dg(v, H0_LSB, 4);
    return m12 ? (h >= 1 && h <= 12) : (h <= 23);
  endfunction

  function automatic int secs_of(logic [19:0] v, bit pm, bit m12);
    int h;
    h = dg(v, H1_LSB, 2) * 10 + dg(v, H0_LSB, 4);
    if (m12) begin
      if (h == 12) h = pm ? 12 : 0;
      else if (pm) h = h + 12;
    end
    return h * 3600 + (dg(v, M1_LSB, 3) * 10 + dg(v, M0_LSB, 4)) * 60 +
           dg(v, S1_LSB, 3) * 10 + dg(v, S0_LSB, 4);
  endfunction

  function automatic logic [19:0] exp_disp(int t, bit m12);
    int h = t / 3600;
    if (m12) begin
      if (h == 0) h = 12;
      else if (h > 12) h = h - 12;
    end
    return pk(h, (t / 60) % 60, t % 60);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (seconds-of-day arithmetic) ----------
  int      m_t = 0;
  int      m_presc = 0;
  bit      m_tick = 0, m_err = 0, m_mode = 0;
  int      m_slot [NA];
  bit      m_en   [NA];
  bit      m_ring [NA];
  bit      chk_on = 0;

  always @(posedge clk) begin
    bit ok_set, aok;
    bit [NA-1:0] match;
    if (rst) begin
      m_t = 0; m_presc = 0; m_tick = 0; m_err = 0; m_mode = 0;
      for (int i = 0; i < NA; i++) begin m_slot[i] = 0; m_en[i] = 0; m_ring[i] = 0; end
      chk_on = 1;
    end else begin
      ok_set = set_time && time_ok(set_value, mode_12h);
      aok    = time_ok(alarm_value, 1'b0);
      m_err  = (set_time && !ok_set) || (alarm_wr && !aok);
      m_tick = 0;
      match  = '0;
      if (ok_set) begin
        m_t = secs_of(set_value, set_pm, mode_12h);
        m_presc = 0;
      end else if (m_presc == CLK_DIV - 1) begin
        m_presc = 0;
        m_t = (m_t + 1) % DAY;
        m_tick = 1;
        for (int i = 0; i < NA; i++) if (m_en[i] && m_slot[i] == m_t) match[i] = 1;
      end else begin
        m_presc++;
      end
      for (int i = 0; i < NA; i++) m_ring[i] = match[i] | (m_ring[i] & !alarm_ack[i]);
      if (alarm_wr && aok && alarm_id < NA) begin
        m_slot[alarm_id] = secs_of(alarm_value, 1'b0, 1'b0);
        m_en[alarm_id]   = alarm_en_in;
        m_ring[alarm_id] = 0;
      end
      m_mode = mode_12h;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [NA-1:0] er;
      for (int i = 0; i < NA; i++) er[i] = m_ring[i];
      chk("model_hh_mm_ss", hh_mm_ss, exp_disp(m_t, m_mode));
      chk("model_am_pm", am_pm, (m_t / 3600) >= 12);
      chk("model_sec_tick", sec_tick, m_tick);
      chk("model_set_err", set_err, m_err);
      chk("model_alarm_ring", alarm_ring, er);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_set(logic [19:0] v, logic pm);
    set_value = v; set_pm = pm; set_time = 1'b1;
    cyc(1);
    set_time = 1'b0;
  endtask

  task automatic do_alarm(int id, logic [19:0] v, logic en);
    alarm_id = AW'(id); alarm_value = v; alarm_en_in = en; alarm_wr = 1'b1;
    cyc(1);
    alarm_wr = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("reset_hh", hh_mm_ss, pk(0, 0, 0));
    chk("reset_tick", sec_tick, 0);
    chk("reset_ring", alarm_ring, 0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      chk("tick_phase", sec_tick, (k % 2) == 0);
    end
    chk("run6_hh", hh_mm_ss, pk(0, 0, 3));

    do_set(pk(23, 59, 59), 0);
    chk("set_235959", hh_mm_ss, pk(23, 59, 59));
    cyc(2);
    chk("rollover_hh", hh_mm_ss, pk(0, 0, 0));
    chk("rollover_ampm", am_pm, 0);
    chk("rollover_ring", alarm_ring, 0);

    mode_12h = 1'b1;
    do_set(pk(12, 0, 0), 0);
    chk("12am_disp", hh_mm_ss, pk(12, 0, 0));
    chk("12am_ampm", am_pm, 0);
    mode_12h = 1'b0;
    cyc(1);
    chk("12am_internal", hh_mm_ss, pk(0, 0, 0));
    mode_12h = 1'b1;
    do_set(pk(1, 5, 0), 1);
    chk("1pm_disp", hh_mm_ss, pk(1, 5, 0));
    chk("1pm_ampm", am_pm, 1);
    mode_12h = 1'b0;
    cyc(1);
    chk("1pm_internal", hh_mm_ss, pk(13, 5, 0));

    do_alarm(2, pk(7, 0, 0), 1);
    do_set(pk(6, 59, 59), 0);
    cyc(2);
    chk("alarm_ring_set", alarm_ring, 4'b0100);
    chk("alarm_time", hh_mm_ss, pk(7, 0, 0));
    do_set(pk(6, 59, 59), 0);
    cyc(1);
    alarm_ack = 4'b0100;
    cyc(1);
    chk("ack_vs_match", alarm_ring, 4'b0100);
    cyc(1);
    chk("ack_clears", alarm_ring, 4'b0000);
    alarm_ack = '0;
    do_set(pk(6, 59, 59), 0);
    cyc(1);
    do_alarm(2, pk(7, 0, 0), 1);
    chk("write_vs_match", alarm_ring, 4'b0000);

    do_set(pk_d(2, 4, 0, 0, 0, 0), 0);
    chk("bad_hour_err", set_err, 1);
    chk("bad_hour_time", hh_mm_ss, pk(7, 0, 0));
    cyc(1);
    do_set(pk_d(1, 2, 6, 0, 0, 0), 0);
    chk("bad_min_err", set_err, 1);
    chk("bad_min_time", hh_mm_ss, pk(7, 0, 1));
    cyc(1);
    chk("err_one_cycle", set_err, 0);

    do_set(pk(0, 0, 4), 0);
    do_alarm(5, pk(0, 0, 5), 1);
    chk("oob_id_no_err", set_err, 0);
    cyc(4);
    chk("oob_id_time", hh_mm_ss, pk(0, 0, 6));
    chk("oob_id_ring", alarm_ring, 0);
    do_alarm(1, pk_d(0, 0, 0, 0, 6, 0), 1);
    chk("bad_alarm_err", set_err, 1);

    do_set(pk(0, 0, 0), 0);
    cyc(1);
    do_set(pk(10, 20, 30), 0);
    chk("wrap_set_hh", hh_mm_ss, pk(10, 20, 30));
    chk("wrap_set_tick", sec_tick, 0);
    cyc(1);
    chk("wrap_hold_hh", hh_mm_ss, pk(10, 20, 30));
    chk("wrap_hold_tick", sec_tick, 0);
    cyc(1);
    chk("wrap_next_hh", hh_mm_ss, pk(10, 20, 31));
    chk("wrap_next_tick", sec_tick, 1);

    for (int c = 0; c < 3000; c++) begin
      set_time = ($urandom_range(0, 19) == 0);
      set_pm   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        set_value = mode_12h ? pk($urandom_range(1, 12), $urandom_range(0, 59), $urandom_range(0, 59))
                             : pk($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      else
        set_value = 20'($urandom);
      alarm_wr    = ($urandom_range(0, 29) == 0);
      alarm_id    = AW'($urandom_range(0, 7));
      alarm_en_in = ($urandom_range(0, 3) != 0);
      alarm_value = ($urandom_range(0, 3) == 0) ? 20'($urandom)
                                                : pk_secs((m_t + $urandom_range(1, 6)) % DAY);
      alarm_ack   = ($urandom_range(0, 9) == 0) ? NA'($urandom) : '0;
      if ($urandom_range(0, 49) == 0) mode_12h = ~mode_12h;
      rst = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    rst = 1'b0; set_time = 1'b0; alarm_wr = 1'b0; alarm_ack = '0;
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
